// File: rtl/atm_pkg.sv
// Shared encodings for the ATM session controller: operation codes, response
// status codes and the session FSM state.
package atm_pkg;

  typedef enum logic [2:0] {
    OP_DEP  = 3'd0,
    OP_WDR  = 3'd1,
    OP_BAL  = 3'd2,
    OP_XFR  = 3'd3,
    OP_EXIT = 3'd4
  } op_e;

  typedef enum logic [3:0] {
    STS_OK       = 4'd0,
    STS_NO_ACCT  = 4'd1,
    STS_BAD_PIN  = 4'd2,
    STS_LOCKED   = 4'd3,
    STS_INSUFF   = 4'd4,
    STS_OVERFLOW = 4'd5,
    STS_BAD_DST  = 4'd6,
    STS_BAD_OP   = 4'd7,
    STS_BAD_AMT  = 4'd8,
    STS_TIMEOUT  = 4'd9
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_PIN = 2'd1,
    S_MENU     = 2'd2,
    S_RESP     = 2'd3
  } state_e;

endpackage

// File: rtl/atm_acct_table.sv
// Account storage: account/PIN/balance entries plus per-entry lock and try count,
// two account-number lookups (card and transfer destination) and a read port.
module atm_acct_table
  import atm_pkg::*;
#(
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned NUM_ACCT  = 4,
  parameter int unsigned MAX_TRIES = 3,
  localparam int unsigned IDX_W    = $clog2(NUM_ACCT),
  localparam int unsigned TRY_W    = $clog2(MAX_TRIES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_en_i,
  input  logic [IDX_W-1:0]  ld_idx_i,
  input  logic [DATA_W-1:0] ld_acct_i,
  input  logic [DATA_W-1:0] ld_pin_i,
  input  logic [DATA_W-1:0] ld_bal_i,
  input  logic [DATA_W-1:0] a_key_i,
  output logic              a_hit_c_o,
  output logic [IDX_W-1:0]  a_idx_c_o,
  input  logic [DATA_W-1:0] b_key_i,
  output logic              b_hit_c_o,
  output logic [IDX_W-1:0]  b_idx_c_o,
  output logic [DATA_W-1:0] b_bal_c_o,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [DATA_W-1:0] rd_pin_c_o,
  output logic [DATA_W-1:0] rd_bal_c_o,
  output logic [TRY_W-1:0]  rd_tries_c_o,
  output logic              rd_locked_c_o,
  input  logic [IDX_W-1:0]  cur_idx_i,
  input  logic              src_we_i,
  input  logic [DATA_W-1:0] src_bal_i,
  input  logic              dst_we_i,
  input  logic [IDX_W-1:0]  dst_idx_i,
  input  logic [DATA_W-1:0] dst_bal_i,
  input  logic              try_we_i,
  input  logic [TRY_W-1:0]  try_val_i,
  input  logic              lock_set_i
);

  logic [DATA_W-1:0] acct_q   [NUM_ACCT];
  logic [DATA_W-1:0] pin_q    [NUM_ACCT];
  logic [DATA_W-1:0] bal_q    [NUM_ACCT];
  logic [TRY_W-1:0]  tries_q  [NUM_ACCT];
  logic              locked_q [NUM_ACCT];

  // Downward scan so a duplicated account number resolves to the lowest index.
  always_comb begin
    a_hit_c_o = 1'b0;
    a_idx_c_o = '0;
    b_hit_c_o = 1'b0;
    b_idx_c_o = '0;
    for (int i = NUM_ACCT - 1; i >= 0; i--) begin
      if (acct_q[i] == a_key_i) begin
        a_hit_c_o = 1'b1;
        a_idx_c_o = IDX_W'(i);
      end
      if (acct_q[i] == b_key_i) begin
        b_hit_c_o = 1'b1;
        b_idx_c_o = IDX_W'(i);
      end
    end
  end

  assign b_bal_c_o     = bal_q[b_idx_c_o];
  assign rd_pin_c_o    = pin_q[rd_idx_i];
  assign rd_bal_c_o    = bal_q[rd_idx_i];
  assign rd_tries_c_o  = tries_q[rd_idx_i];
  assign rd_locked_c_o = locked_q[rd_idx_i];

  // Table load wins over any session write aimed at the same entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ACCT; i++) begin
        acct_q[i]   <= '0;
        pin_q[i]    <= '0;
        bal_q[i]    <= '0;
        tries_q[i]  <= '0;
        locked_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_ACCT; i++) begin
        if (ld_en_i && (ld_idx_i == IDX_W'(i))) begin
          acct_q[i]   <= ld_acct_i;
          pin_q[i]    <= ld_pin_i;
          bal_q[i]    <= ld_bal_i;
          tries_q[i]  <= '0;
          locked_q[i] <= 1'b0;
        end else begin
          if (src_we_i && (cur_idx_i == IDX_W'(i))) bal_q[i] <= src_bal_i;
          if (dst_we_i && (dst_idx_i == IDX_W'(i))) bal_q[i] <= dst_bal_i;
          if (try_we_i && (cur_idx_i == IDX_W'(i))) tries_q[i] <= try_val_i;
          if (lock_set_i && (cur_idx_i == IDX_W'(i))) locked_q[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/atm_session_ctrl.sv
// ATM session controller: card/PIN/operation handshake, one registered response
// pulse per accepted request, idle timeout, backed by atm_acct_table.
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned NUM_ACCT    = 4,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned TIMEOUT_CYC = 1024,
  localparam int unsigned IDX_W      = $clog2(NUM_ACCT),
  localparam int unsigned TRY_W      = $clog2(MAX_TRIES + 1),
  localparam int unsigned TMO_W      = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_en,
  input  logic [IDX_W-1:0]  ld_idx,
  input  logic [DATA_W-1:0] ld_acct,
  input  logic [DATA_W-1:0] ld_pin,
  input  logic [DATA_W-1:0] ld_bal,
  input  logic              card_valid,
  input  logic [DATA_W-1:0] card_acct,
  input  logic              pin_valid,
  input  logic [DATA_W-1:0] pin,
  input  logic              op_valid,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] amount,
  input  logic [DATA_W-1:0] dst_acct,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [3:0]        resp_status,
  output logic [DATA_W-1:0] resp_bal,
  output logic [DATA_W-1:0] resp_dst_bal,
  output logic              session_active,
  output logic              acct_locked
);

  state_e            state_q, state_d, ret_q, ret_d;
  logic [IDX_W-1:0]  cur_idx_q, cur_idx_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              resp_valid_q, resp_valid_d;
  status_e           resp_status_q, resp_status_d;
  logic [DATA_W-1:0] resp_bal_q, resp_bal_d;
  logic [DATA_W-1:0] resp_dst_bal_q, resp_dst_bal_d;
  logic              req_ready_q, req_ready_d;
  logic              session_active_q, session_active_d;
  logic              acct_locked_q, acct_locked_d;

  logic              a_hit_c, b_hit_c, rd_locked_c;
  logic [IDX_W-1:0]  a_idx_c, b_idx_c, rd_idx_c;
  logic [DATA_W-1:0] b_bal_c, rd_pin_c, rd_bal_c;
  logic [TRY_W-1:0]  rd_tries_c, try_next_c, try_val_c;
  logic              src_we_c, dst_we_c, try_we_c, lock_set_c;
  logic [DATA_W-1:0] src_bal_c, dst_bal_c;
  logic [DATA_W:0]   dep_sum_c, dst_sum_c;
  logic              card_acc_c, pin_acc_c, op_acc_c, tmo_hit_c;

  assign rd_idx_c   = (state_q == S_IDLE) ? a_idx_c : cur_idx_q;
  assign try_next_c = rd_tries_c + TRY_W'(1);
  assign dep_sum_c  = {1'b0, rd_bal_c} + {1'b0, amount};
  assign dst_sum_c  = {1'b0, b_bal_c} + {1'b0, amount};
  assign card_acc_c = req_ready_q && card_valid && (state_q == S_IDLE);
  assign pin_acc_c  = req_ready_q && pin_valid && (state_q == S_WAIT_PIN);
  assign op_acc_c   = req_ready_q && op_valid && (state_q == S_MENU);
  assign tmo_hit_c  = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  atm_acct_table #(
    .DATA_W    (DATA_W),
    .NUM_ACCT  (NUM_ACCT),
    .MAX_TRIES (MAX_TRIES)
  ) u_table (
    .clk           (clk),
    .rst_n         (rst_n),
    .ld_en_i       (ld_en),
    .ld_idx_i      (ld_idx),
    .ld_acct_i     (ld_acct),
    .ld_pin_i      (ld_pin),
    .ld_bal_i      (ld_bal),
    .a_key_i       (card_acct),
    .a_hit_c_o     (a_hit_c),
    .a_idx_c_o     (a_idx_c),
    .b_key_i       (dst_acct),
    .b_hit_c_o     (b_hit_c),
    .b_idx_c_o     (b_idx_c),
    .b_bal_c_o     (b_bal_c),
    .rd_idx_i      (rd_idx_c),
    .rd_pin_c_o    (rd_pin_c),
    .rd_bal_c_o    (rd_bal_c),
    .rd_tries_c_o  (rd_tries_c),
    .rd_locked_c_o (rd_locked_c),
    .cur_idx_i     (cur_idx_q),
    .src_we_i      (src_we_c),
    .src_bal_i     (src_bal_c),
    .dst_we_i      (dst_we_c),
    .dst_idx_i     (b_idx_c),
    .dst_bal_i     (dst_bal_c),
    .try_we_i      (try_we_c),
    .try_val_i     (try_val_c),
    .lock_set_i    (lock_set_c)
  );

  // Next-state, response and table-write decode; ret_d is where RESP returns to.
  always_comb begin
    state_d        = state_q;
    ret_d          = ret_q;
    cur_idx_d      = cur_idx_q;
    tmo_d          = tmo_q;
    resp_valid_d   = 1'b0;
    resp_status_d  = resp_status_q;
    resp_bal_d     = resp_bal_q;
    resp_dst_bal_d = resp_dst_bal_q;
    acct_locked_d  = acct_locked_q;
    src_we_c       = 1'b0;
    src_bal_c      = rd_bal_c;
    dst_we_c       = 1'b0;
    dst_bal_c      = b_bal_c;
    try_we_c       = 1'b0;
    try_val_c      = rd_tries_c;
    lock_set_c     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (card_acc_c) begin
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
          ret_d        = S_IDLE;
          if (!a_hit_c) begin
            resp_status_d = STS_NO_ACCT;
            acct_locked_d = 1'b0;
          end else if (rd_locked_c) begin
            resp_status_d = STS_LOCKED;
            acct_locked_d = 1'b1;
            cur_idx_d     = a_idx_c;
          end else begin
            resp_status_d = STS_OK;
            acct_locked_d = 1'b0;
            cur_idx_d     = a_idx_c;
            ret_d         = S_WAIT_PIN;
          end
        end
      end

      S_WAIT_PIN: begin
        if (pin_acc_c) begin
          tmo_d        = '0;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
          try_we_c     = 1'b1;
          if (pin == rd_pin_c) begin
            resp_status_d = STS_OK;
            try_val_c     = '0;
            ret_d         = S_MENU;
          end else if (try_next_c >= TRY_W'(MAX_TRIES)) begin
            resp_status_d = STS_LOCKED;
            try_val_c     = try_next_c;
            lock_set_c    = 1'b1;
            acct_locked_d = 1'b1;
            ret_d         = S_IDLE;
          end else begin
            resp_status_d = STS_BAD_PIN;
            try_val_c     = try_next_c;
            ret_d         = S_WAIT_PIN;
          end
        end else if (tmo_hit_c) begin
          tmo_d         = '0;
          resp_valid_d  = 1'b1;
          resp_status_d = STS_TIMEOUT;
          state_d       = S_RESP;
          ret_d         = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      S_MENU: begin
        if (op_acc_c) begin
          tmo_d         = '0;
          resp_valid_d  = 1'b1;
          state_d       = S_RESP;
          ret_d         = S_MENU;
          resp_status_d = STS_OK;
          resp_bal_d    = rd_bal_c;
          unique case (op)
            OP_DEP: begin
              if (amount == '0) resp_status_d = STS_BAD_AMT;
              else if (dep_sum_c[DATA_W]) resp_status_d = STS_OVERFLOW;
              else begin
                src_we_c   = 1'b1;
                src_bal_c  = dep_sum_c[DATA_W-1:0];
                resp_bal_d = dep_sum_c[DATA_W-1:0];
              end
            end
            OP_WDR: begin
              if (amount == '0) resp_status_d = STS_BAD_AMT;
              else if (amount > rd_bal_c) resp_status_d = STS_INSUFF;
              else begin
                src_we_c   = 1'b1;
                src_bal_c  = rd_bal_c - amount;
                resp_bal_d = rd_bal_c - amount;
              end
            end
            OP_BAL: ;
            OP_XFR: begin
              if (amount == '0) resp_status_d = STS_BAD_AMT;
              else if (!b_hit_c || (b_idx_c == cur_idx_q)) resp_status_d = STS_BAD_DST;
              else begin
                resp_dst_bal_d = b_bal_c;
                if (amount > rd_bal_c) resp_status_d = STS_INSUFF;
                else if (dst_sum_c[DATA_W]) resp_status_d = STS_OVERFLOW;
                else begin
                  src_we_c       = 1'b1;
                  src_bal_c      = rd_bal_c - amount;
                  dst_we_c       = 1'b1;
                  dst_bal_c      = dst_sum_c[DATA_W-1:0];
                  resp_bal_d     = rd_bal_c - amount;
                  resp_dst_bal_d = dst_sum_c[DATA_W-1:0];
                end
              end
            end
            OP_EXIT: ret_d = S_IDLE;
            default: resp_status_d = STS_BAD_OP;
          endcase
        end else if (tmo_hit_c) begin
          tmo_d         = '0;
          resp_valid_d  = 1'b1;
          resp_status_d = STS_TIMEOUT;
          state_d       = S_RESP;
          ret_d         = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      S_RESP: state_d = ret_q;

      default: state_d = S_IDLE;
    endcase

    // A reload of the current entry always unlocks it, whatever the session did.
    if (ld_en && (ld_idx == cur_idx_q)) acct_locked_d = 1'b0;

    req_ready_d      = (state_d != S_RESP);
    session_active_d = (state_d == S_WAIT_PIN) || (state_d == S_MENU) ||
                       ((state_d == S_RESP) && (ret_d != S_IDLE));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      ret_q            <= S_IDLE;
      cur_idx_q        <= '0;
      tmo_q            <= '0;
      resp_valid_q     <= 1'b0;
      resp_status_q    <= STS_OK;
      resp_bal_q       <= '0;
      resp_dst_bal_q   <= '0;
      req_ready_q      <= 1'b0;
      session_active_q <= 1'b0;
      acct_locked_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      ret_q            <= ret_d;
      cur_idx_q        <= cur_idx_d;
      tmo_q            <= tmo_d;
      resp_valid_q     <= resp_valid_d;
      resp_status_q    <= resp_status_d;
      resp_bal_q       <= resp_bal_d;
      resp_dst_bal_q   <= resp_dst_bal_d;
      req_ready_q      <= req_ready_d;
      session_active_q <= session_active_d;
      acct_locked_q    <= acct_locked_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_status    = resp_status_q;
  assign resp_bal       = resp_bal_q;
  assign resp_dst_bal   = resp_dst_bal_q;
  assign session_active = session_active_q;
  assign acct_locked    = acct_locked_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed bench for atm_session_ctrl: card/PIN/operation sequences with
// hand-computed status and balance expectations, timeout and mid-response reset.
module tb_atm_session_ctrl;

  localparam int unsigned DW   = 12;
  localparam int unsigned NA   = 4;
  localparam int unsigned TMO  = 1024;

  localparam logic [2:0] DEP = 3'd0, WDR = 3'd1, BAL = 3'd2, XFR = 3'd3, EXT = 3'd4;
  localparam logic [3:0] OK = 4'd0, NO_ACCT = 4'd1, BAD_PIN = 4'd2, LOCKED = 4'd3,
                         INSUFF = 4'd4, OVERFLOW = 4'd5, BAD_DST = 4'd6,
                         BAD_OP = 4'd7, BAD_AMT = 4'd8, TIMEOUT = 4'd9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ld_en = 1'b0;
  logic [1:0]    ld_idx = '0;
  logic [DW-1:0] ld_acct = '0, ld_pin = '0, ld_bal = '0;
  logic          card_valid = 1'b0;
  logic [DW-1:0] card_acct = '0;
  logic          pin_valid = 1'b0;
  logic [DW-1:0] pin = '0;
  logic          op_valid = 1'b0;
  logic [2:0]    op = '0;
  logic [DW-1:0] amount = '0, dst_acct = '0;
  logic          req_ready, resp_valid, session_active, acct_locked;
  logic [3:0]    resp_status;
  logic [DW-1:0] resp_bal, resp_dst_bal;

  int n_tests = 0;
  int n_fail  = 0;

  atm_session_ctrl #(
    .DATA_W(DW), .NUM_ACCT(NA), .MAX_TRIES(3), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_acct(ld_acct), .ld_pin(ld_pin), .ld_bal(ld_bal),
    .card_valid(card_valid), .card_acct(card_acct),
    .pin_valid(pin_valid), .pin(pin),
    .op_valid(op_valid), .op(op), .amount(amount), .dst_acct(dst_acct),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_status(resp_status),
    .resp_bal(resp_bal), .resp_dst_bal(resp_dst_bal),
    .session_active(session_active), .acct_locked(acct_locked)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [1:0] idx, input logic [DW-1:0] a,
                      input logic [DW-1:0] p, input logic [DW-1:0] b);
    ld_en = 1'b1; ld_idx = idx; ld_acct = a; ld_pin = p; ld_bal = b;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic card(input string tag, input logic [DW-1:0] a, input logic [3:0] st);
    card_valid = 1'b1; card_acct = a;
    tick();
    card_valid = 1'b0;
    chk({tag, "_pulse"}, 32'(resp_valid), 32'd1);
    chk({tag, "_status"}, 32'(resp_status), 32'(st));
    tick();
  endtask

  task automatic enter_pin(input string tag, input logic [DW-1:0] p, input logic [3:0] st);
    pin_valid = 1'b1; pin = p;
    tick();
    pin_valid = 1'b0;
    chk({tag, "_pulse"}, 32'(resp_valid), 32'd1);
    chk({tag, "_status"}, 32'(resp_status), 32'(st));
    tick();
  endtask

  task automatic do_op(input string tag, input logic [2:0] o, input logic [DW-1:0] amt,
                       input logic [DW-1:0] dst, input logic [3:0] st,
                       input logic [DW-1:0] bal, input logic [DW-1:0] dbal, input bit cd);
    op_valid = 1'b1; op = o; amount = amt; dst_acct = dst;
    tick();
    op_valid = 1'b0;
    chk({tag, "_pulse"}, 32'(resp_valid), 32'd1);
    chk({tag, "_status"}, 32'(resp_status), 32'(st));
    chk({tag, "_bal"}, 32'(resp_bal), 32'(bal));
    if (cd) chk({tag, "_dst_bal"}, 32'(resp_dst_bal), 32'(dbal));
    tick();
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_session", 32'(session_active), 32'd0);
    chk("rst_bal", 32'(resp_bal), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_req_ready", 32'(req_ready), 32'd1);

    // Basic session: deposit and withdrawals on idx0.
    load(2'd0, 12'h123, 12'h456, 12'd100);
    card("card_ok", 12'h123, OK);
    chk("card_ok_session", 32'(session_active), 32'd1);
    enter_pin("pin_ok", 12'h456, OK);
    do_op("dep50", DEP, 12'd50, 12'h0, OK, 12'd150, 12'd0, 1'b0);
    do_op("wdr150", WDR, 12'd150, 12'h0, OK, 12'd0, 12'd0, 1'b0);
    do_op("wdr1", WDR, 12'd1, 12'h0, INSUFF, 12'd0, 12'd0, 1'b0);
    do_op("dep0", DEP, 12'd0, 12'h0, BAD_AMT, 12'd0, 12'd0, 1'b0);
    do_op("badop", 3'd5, 12'd3, 12'h0, BAD_OP, 12'd0, 12'd0, 1'b0);
    do_op("bal0", BAL, 12'd0, 12'h0, OK, 12'd0, 12'd0, 1'b0);
    do_op("exit", EXT, 12'd0, 12'h0, OK, 12'd0, 12'd0, 1'b0);
    chk("exit_session", 32'(session_active), 32'd0);
    card("card_none", 12'h999, NO_ACCT);

    // Wrong PIN three times locks the entry; reload unlocks it.
    card("card_lk", 12'h123, OK);
    enter_pin("badpin1", 12'h001, BAD_PIN);
    enter_pin("badpin2", 12'h002, BAD_PIN);
    enter_pin("badpin3", 12'h003, LOCKED);
    chk("lock_flag", 32'(acct_locked), 32'd1);
    chk("lock_session", 32'(session_active), 32'd0);
    card("card_locked", 12'h123, LOCKED);
    chk("lock_flag2", 32'(acct_locked), 32'd1);
    load(2'd0, 12'h123, 12'h456, 12'd100);
    chk("unlock_flag", 32'(acct_locked), 32'd0);

    // Transfers between idx0 and idx1.
    load(2'd1, 12'h200, 12'h111, 12'd4090);
    card("card_x", 12'h123, OK);
    enter_pin("pin_x", 12'h456, OK);
    do_op("xfr10", XFR, 12'd10, 12'h200, OVERFLOW, 12'd100, 12'd4090, 1'b1);
    do_op("xfr5", XFR, 12'd5, 12'h200, OK, 12'd95, 12'd4095, 1'b1);
    do_op("xfr_self", XFR, 12'd5, 12'h123, BAD_DST, 12'd95, 12'd4095, 1'b1);
    do_op("xfr_unk", XFR, 12'd5, 12'h777, BAD_DST, 12'd95, 12'd0, 1'b0);
    do_op("xfr_insuff", XFR, 12'd200, 12'h200, INSUFF, 12'd95, 12'd4095, 1'b1);
    do_op("xfr0", XFR, 12'd0, 12'h200, BAD_AMT, 12'd95, 12'd0, 1'b0);

    // Load and session deposit to the same entry in one cycle: load wins.
    op_valid = 1'b1; op = DEP; amount = 12'd1;
    ld_en = 1'b1; ld_idx = 2'd0; ld_acct = 12'h123; ld_pin = 12'h456; ld_bal = 12'd7;
    tick();
    op_valid = 1'b0; ld_en = 1'b0;
    chk("ldprio_status", 32'(resp_status), 32'(OK));
    chk("ldprio_resp_bal", 32'(resp_bal), 32'd96);
    tick();
    do_op("ldprio_bal", BAL, 12'd0, 12'h0, OK, 12'd7, 12'd0, 1'b0);
    do_op("exit2", EXT, 12'd0, 12'h0, OK, 12'd7, 12'd0, 1'b0);

    // Duplicate account number resolves to the lowest index (idx1, PIN 0x111).
    load(2'd2, 12'h200, 12'h222, 12'd50);
    card("card_dup", 12'h200, OK);
    enter_pin("pin_dup_hi", 12'h222, BAD_PIN);
    enter_pin("pin_dup_lo", 12'h111, OK);
    do_op("bal_dup", BAL, 12'd0, 12'h0, OK, 12'd4095, 12'd0, 1'b0);

    // A held valid yields one pulse; the copy seen during RESP is dropped.
    op_valid = 1'b1; op = BAL;
    tick();
    chk("hold_pulse1", 32'(resp_valid), 32'd1);
    chk("hold_ready_resp", 32'(req_ready), 32'd0);
    tick();
    op_valid = 1'b0;
    chk("hold_nopulse1", 32'(resp_valid), 32'd0);
    tick();
    chk("hold_nopulse2", 32'(resp_valid), 32'd0);

    // Idle timeout counted from a fresh accept.
    do_op("bal_pre_tmo", BAL, 12'd0, 12'h0, OK, 12'd4095, 12'd0, 1'b0);
    n = 0;
    while (!resp_valid && n < 2000) begin
      tick();
      n++;
    end
    chk("tmo_cycles", 32'(n), 32'(TMO));
    chk("tmo_status", 32'(resp_status), 32'(TIMEOUT));
    chk("tmo_session", 32'(session_active), 32'd0);
    chk("tmo_bal_hold", 32'(resp_bal), 32'd4095);
    tick();
    chk("tmo_one_pulse", 32'(resp_valid), 32'd0);

    // Reset asserted right at the accept edge: the response never appears.
    card_valid = 1'b1; card_acct = 12'h123;
    @(posedge clk);
    rst_n = 1'b0;
    card_valid = 1'b0;
    #1;
    chk("rstmid_pulse", 32'(resp_valid), 32'd0);
    chk("rstmid_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstmid_nopulse", 32'(resp_valid), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    chk("rstmid_nopulse_rel", 32'(resp_valid), 32'd0);
    card("post_rst_old", 12'h123, NO_ACCT);
    card("post_rst_zero", 12'h000, OK);
    enter_pin("post_rst_pin", 12'h000, OK);
    do_op("post_rst_bal", BAL, 12'd0, 12'h0, OK, 12'd0, 12'd0, 1'b0);
    do_op("post_rst_xfr", XFR, 12'd1, 12'h000, BAD_DST, 12'd0, 12'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/atm_session_ctrl.md
ATM_SESSION_CTRL -- requirements
Module: atm_session_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 12: width of account number, PIN, balance and amount.
REQ-002 SHALL have parameter NUM_ACCT, default 4: account table depth, ≥2.
REQ-003 SHALL have parameter MAX_TRIES, default 3: wrong-PIN attempts before an account locks.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1024: idle cycles before a session aborts.
REQ-005 SHALL have port clk, input, 1 bit: single clock for all state.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have ports ld_en/ld_idx/ld_acct/ld_pin/ld_bal, inputs, 1/clog2(NUM_ACCT)/DATA_W/DATA_W/DATA_W bits: table write port; ld_en also clears the lock and try count of that entry.
REQ-008 SHALL have ports card_valid/card_acct, inputs, 1/DATA_W bits: card insertion request.
REQ-009 SHALL have ports pin_valid/pin, inputs, 1/DATA_W bits: PIN entry request.
REQ-010 SHALL have ports op_valid/op/amount/dst_acct, inputs, 1/3/DATA_W/DATA_W bits: operation request; op codes are DEP=0, WDR=1, BAL=2, XFR=3, EXIT=4.
REQ-011 SHALL have port req_ready, output, 1 bit: a request is accepted on valid && req_ready.
REQ-012 SHALL have ports resp_valid/resp_status, outputs, 1/4 bits: single-cycle response pulse with status code.
REQ-013 SHALL have ports resp_bal/resp_dst_bal, outputs, DATA_W each: source balance and destination balance after the operation.
REQ-014 SHALL have ports session_active/acct_locked, outputs, 1 bit each: session open; the current card is locked.

Function
REQ-015 SHALL use FSM states IDLE, WAIT_PIN, MENU, RESP, and SHALL assert req_ready only in IDLE (card), WAIT_PIN (pin) and MENU (op).
REQ-016 SHALL, on card accept: if no match then NO_ACCT and stay IDLE; if locked then LOCKED and stay IDLE; else OK, go to WAIT_PIN and latch the index.
REQ-017 SHALL, on pin accept: if the PIN matches, reply OK, clear the try count and go to MENU; otherwise increment the try count and reply BAD_PIN.
REQ-018 SHALL, when the try count reaches MAX_TRIES, set the lock, reply LOCKED and go to IDLE.
REQ-019 SHALL give every accepted request exactly one resp_valid pulse, in the cycle after acceptance; no new request is accepted during RESP.
REQ-020 SHALL handle DEP: if bal+amount exceeds 2^DATA_W-1, reply OVERFLOW with the balance unchanged; otherwise OK with the balance updated.
REQ-021 SHALL handle WDR: if amount > bal, reply INSUFF; otherwise OK with bal-amount; amount == bal is legal and gives 0.
REQ-022 SHALL handle XFR: unknown dst or dst == source gives BAD_DST; amount > bal gives INSUFF; dst overflow gives OVERFLOW; otherwise update both balances in the same edge and reply OK.
REQ-023 SHALL handle BAL: reply OK with the current balance and no table write.
REQ-024 SHALL handle EXIT: reply OK and go to IDLE.
REQ-025 SHALL handle undefined op codes: reply BAD_OP and stay in MENU.
REQ-026 SHALL reply BAD_AMT for DEP, WDR or XFR with amount == 0, with no table write.
REQ-027 SHALL use status codes OK=0, NO_ACCT=1, BAD_PIN=2, LOCKED=3, INSUFF=4, OVERFLOW=5, BAD_DST=6, BAD_OP=7, BAD_AMT=8, TIMEOUT=9.
REQ-028 SHALL count idle cycles in WAIT_PIN/MENU; the counter clears on any accept, and on reaching TIMEOUT_CYC the block pulses TIMEOUT and goes to IDLE.
REQ-029 SHALL give ld_en priority over a same-cycle session write to the same entry.
REQ-030 SHALL resolve a duplicate account number in the table to the lowest index.
REQ-031 SHALL drive resp_bal/resp_dst_bal from registers that hold their value between pulses.
REQ-032 SHALL ignore valid signals when req_ready is low; they are not queued.

Reset
REQ-033 SHALL, on rst_n low, immediately go to IDLE with all outputs 0, every balance/PIN/account entry 0, every lock and try count cleared, and the timeout counter at 0.
REQ-034 SHALL, on reset mid-session, abandon any unissued response; no pulse follows reset.

Structure
REQ-035 SHALL place the op codes, status codes and state enum in shared package atm_pkg.
REQ-036 SHALL place the account storage, lookup by account number and the lock/try registers in sub-module atm_acct_table.

Verification
REQ-037 SHALL cover: load idx0 {acct=0x123, pin=0x456, bal=100}; card 0x123, pin 0x456, DEP 50 -> OK, resp_bal=150.
REQ-038 SHALL cover: WDR 150 -> OK, resp_bal=0; then WDR 1 -> INSUFF, resp_bal=0.
REQ-039 SHALL cover: wrong PIN 3 times -> BAD_PIN, BAD_PIN, LOCKED, acct_locked=1; re-insert card -> LOCKED; ld_en on the entry -> unlocked.
REQ-040 SHALL cover: idx1 {0x200, bal=4090}, XFR 10 from 0x123 (bal 100) -> OVERFLOW, balances unchanged; XFR 5 -> OK, resp_bal=95, resp_dst_bal=4095.
REQ-041 SHALL cover: session in MENU, no input for TIMEOUT_CYC cycles -> TIMEOUT pulse, session_active=0.
REQ-042 SHALL cover: assert rst_n low during the RESP cycle -> no resp_valid pulse and all table entries read 0.
